// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared types for the pipeline stall/flush controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MD_BUSY  = 2'd2
    } ctrl_state_t;

    // Encoded value is the priority rank: higher value wins.
    typedef enum logic [2:0] {
        HZ_NONE     = 3'd0,
        HZ_JUMP     = 3'd1,
        HZ_LOAD_USE = 3'd2,
        HZ_BRANCH   = 3'd3,
        HZ_MULDIV   = 3'd4,
        HZ_MEM      = 3'd5
    } hazard_t;

    function automatic hazard_t pick_hazard(
        input logic mem,
        input logic muldiv,
        input logic branch,
        input logic load_use,
        input logic jump
    );
        if (mem)           return HZ_MEM;
        else if (muldiv)   return HZ_MULDIV;
        else if (branch)   return HZ_BRANCH;
        else if (load_use) return HZ_LOAD_USE;
        else if (jump)     return HZ_JUMP;
        return HZ_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_cycle_counter.sv
// ============================================================================
// Module      : muldiv_cycle_counter
// Description : Loadable down-counter with zero flag for mul/div occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_cycle_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush controller for the 5-stage pipeline (memory
//               handshake, mul/div, branch, load-use, jump).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_uses_rs,
    input  logic       ID_uses_rt,
    input  logic       ID_Jump,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_WriteReg,
    input  logic       ID_EX_MulDiv,
    input  logic       EX_BranchTaken,
    input  logic       EX_MEM_MemAccess,
    input  logic       DMem_Ack,
    output logic       DMem_Req,
    output logic       MD_Start,
    output logic       PC_Stall,
    output logic       IF_ID_Stall,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Stall,
    output logic       ID_EX_Flush,
    output logic       EX_MEM_Stall,
    output logic       EX_MEM_Flush,
    output logic       MEM_WB_Stall,
    output logic       MEM_WB_Flush,
    output logic       Busy
);

    localparam int               CNT_W   = $clog2(MULDIV_CYCLES);
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_CYCLES - 2);

    ctrl_state_t state;
    ctrl_state_t next_state;
    logic        mem_done;
    logic        md_zero;
    logic        load_use;
    hazard_t     hazard;

    assign load_use = ID_EX_MemRead && (ID_EX_WriteReg != 5'd0) &&
                      ((ID_uses_rs && (ID_rs == ID_EX_WriteReg)) ||
                       (ID_uses_rt && (ID_rt == ID_EX_WriteReg)));

    // mem_done masks only the access whose Ack was just seen.
    assign hazard = pick_hazard(EX_MEM_MemAccess && !mem_done, ID_EX_MulDiv,
                                EX_BranchTaken, load_use, ID_Jump);

    muldiv_cycle_counter #(
        .WIDTH (CNT_W)
    ) u_md_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (MD_Start),
        .load_value (MD_LOAD),
        .dec        (state == ST_MD_BUSY),
        .zero       (md_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            mem_done <= 1'b0;
        end else begin
            state    <= next_state;
            mem_done <= (state == ST_MEM_WAIT) && DMem_Ack;
        end
    end

    always_comb begin
        next_state   = state;
        DMem_Req     = 1'b0;
        MD_Start     = 1'b0;
        PC_Stall     = 1'b0;
        IF_ID_Stall  = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Stall  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Stall = 1'b0;
        EX_MEM_Flush = 1'b0;
        MEM_WB_Stall = 1'b0;
        MEM_WB_Flush = 1'b0;
        Busy         = 1'b0;
        if (!reset) begin
            Busy = (state != ST_RUN);
            case (state)
                ST_RUN: begin
                    case (hazard)
                        HZ_MEM: begin
                            DMem_Req     = 1'b1;
                            PC_Stall     = 1'b1;
                            IF_ID_Stall  = 1'b1;
                            ID_EX_Stall  = 1'b1;
                            EX_MEM_Stall = 1'b1;
                            MEM_WB_Flush = 1'b1;
                            next_state   = ST_MEM_WAIT;
                        end
                        HZ_MULDIV: begin
                            MD_Start     = 1'b1;
                            PC_Stall     = 1'b1;
                            IF_ID_Stall  = 1'b1;
                            ID_EX_Stall  = 1'b1;
                            EX_MEM_Flush = 1'b1;
                            next_state   = ST_MD_BUSY;
                        end
                        HZ_BRANCH: begin
                            IF_ID_Flush = 1'b1;
                            ID_EX_Flush = 1'b1;
                        end
                        HZ_LOAD_USE: begin
                            PC_Stall    = 1'b1;
                            IF_ID_Stall = 1'b1;
                            ID_EX_Flush = 1'b1;
                        end
                        HZ_JUMP: begin
                            IF_ID_Flush = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM_WAIT: begin
                    if (DMem_Ack) begin
                        next_state = ST_RUN;
                    end else begin
                        PC_Stall     = 1'b1;
                        IF_ID_Stall  = 1'b1;
                        ID_EX_Stall  = 1'b1;
                        EX_MEM_Stall = 1'b1;
                        MEM_WB_Flush = 1'b1;
                    end
                end
                ST_MD_BUSY: begin
                    if (md_zero) begin
                        next_state = ST_RUN;
                    end else begin
                        PC_Stall     = 1'b1;
                        IF_ID_Stall  = 1'b1;
                        ID_EX_Stall  = 1'b1;
                        EX_MEM_Flush = 1'b1;
                    end
                end
                default: next_state = ST_RUN;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl (table + sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipeline_hazard_ctrl;

    // Output vector bit order:
    // 11 DMem_Req, 10 MD_Start, 9 PC_Stall, 8 IF_ID_Stall, 7 IF_ID_Flush,
    // 6 ID_EX_Stall, 5 ID_EX_Flush, 4 EX_MEM_Stall, 3 EX_MEM_Flush,
    // 2 MEM_WB_Stall, 1 MEM_WB_Flush, 0 Busy
    localparam logic [11:0] B_REQ  = 12'h800, B_MDS = 12'h400, B_PCS = 12'h200;
    localparam logic [11:0] B_IFS  = 12'h100, B_IFF = 12'h080, B_IDS = 12'h040;
    localparam logic [11:0] B_IDF  = 12'h020, B_EMS = 12'h010, B_EMF = 12'h008;
    localparam logic [11:0] B_BUSY = 12'h001, B_MWF = 12'h002;

    localparam logic [11:0] NONE   = 12'h000;
    localparam logic [11:0] LU     = B_PCS | B_IFS | B_IDF;
    localparam logic [11:0] BR     = B_IFF | B_IDF;
    localparam logic [11:0] JMP    = B_IFF;
    localparam logic [11:0] MEMR   = B_REQ | B_PCS | B_IFS | B_IDS | B_EMS | B_MWF;
    localparam logic [11:0] MEMW   = B_PCS | B_IFS | B_IDS | B_EMS | B_MWF | B_BUSY;
    localparam logic [11:0] MEMACK = B_BUSY;
    localparam logic [11:0] MDS    = B_MDS | B_PCS | B_IFS | B_IDS | B_EMF;
    localparam logic [11:0] MDB    = B_PCS | B_IFS | B_IDS | B_EMF | B_BUSY;
    localparam logic [11:0] MDEND  = B_BUSY;

    typedef struct {
        string      name;
        logic [4:0] rs, rt, wreg;
        logic       urs, urt, jump, memread, muldiv, br, memacc, ack;
        logic [11:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, ID_EX_WriteReg;
    logic        ID_uses_rs, ID_uses_rt, ID_Jump, ID_EX_MemRead, ID_EX_MulDiv;
    logic        EX_BranchTaken, EX_MEM_MemAccess, DMem_Ack;
    logic [11:0] outs_a, outs_b;

    int          total = 0;
    int          bad   = 0;
    logic        use_b = 1'b0;
    logic [11:0] exp_q[$];
    string       name_q[$];
    vec_t        tbl[12];
    vec_t        cur;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MULDIV_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt), .ID_Jump(ID_Jump),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_WriteReg(ID_EX_WriteReg),
        .ID_EX_MulDiv(ID_EX_MulDiv), .EX_BranchTaken(EX_BranchTaken),
        .EX_MEM_MemAccess(EX_MEM_MemAccess), .DMem_Ack(DMem_Ack),
        .DMem_Req(outs_a[11]), .MD_Start(outs_a[10]), .PC_Stall(outs_a[9]),
        .IF_ID_Stall(outs_a[8]), .IF_ID_Flush(outs_a[7]),
        .ID_EX_Stall(outs_a[6]), .ID_EX_Flush(outs_a[5]),
        .EX_MEM_Stall(outs_a[4]), .EX_MEM_Flush(outs_a[3]),
        .MEM_WB_Stall(outs_a[2]), .MEM_WB_Flush(outs_a[1]), .Busy(outs_a[0])
    );

    pipeline_hazard_ctrl #(.MULDIV_CYCLES(32)) dut_b (
        .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt), .ID_Jump(ID_Jump),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_WriteReg(ID_EX_WriteReg),
        .ID_EX_MulDiv(ID_EX_MulDiv), .EX_BranchTaken(EX_BranchTaken),
        .EX_MEM_MemAccess(EX_MEM_MemAccess), .DMem_Ack(DMem_Ack),
        .DMem_Req(outs_b[11]), .MD_Start(outs_b[10]), .PC_Stall(outs_b[9]),
        .IF_ID_Stall(outs_b[8]), .IF_ID_Flush(outs_b[7]),
        .ID_EX_Stall(outs_b[6]), .ID_EX_Flush(outs_b[5]),
        .EX_MEM_Stall(outs_b[4]), .EX_MEM_Flush(outs_b[3]),
        .MEM_WB_Stall(outs_b[2]), .MEM_WB_Flush(outs_b[1]), .Busy(outs_b[0])
    );

    function automatic vec_t mkv(string n, logic [4:0] rs, logic [4:0] rt,
                                 logic urs, logic urt, logic jump, logic memread,
                                 logic [4:0] wreg, logic br, logic [11:0] exp);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.jump = jump; v.memread = memread; v.wreg = wreg; v.br = br;
        v.muldiv = 1'b0; v.memacc = 1'b0; v.ack = 1'b0; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t idle_v();
        return mkv("idle", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, NONE);
    endfunction

    task automatic check(input string n, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", n, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ID_rs = v.rs; ID_rt = v.rt; ID_uses_rs = v.urs; ID_uses_rt = v.urt;
        ID_Jump = v.jump; ID_EX_MemRead = v.memread; ID_EX_WriteReg = v.wreg;
        ID_EX_MulDiv = v.muldiv; EX_BranchTaken = v.br;
        EX_MEM_MemAccess = v.memacc; DMem_Ack = v.ack;
    endtask

    task automatic step(input vec_t v);
        logic [11:0] e;
        string       n;
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 12'hFFF, 12'h000);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, use_b ? outs_b : outs_a, e);
        end
    endtask

    task automatic sq(input string n, input logic [11:0] e);
        cur.name = n;
        cur.exp  = e;
        step(cur);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        drive(idle_v());
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mkv("tbl_idle",       5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, NONE);
        tbl[1]  = mkv("tbl_lu_rs",      5'd3, 5'd0, 1, 0, 0, 1, 5'd3, 0, LU);
        tbl[2]  = mkv("tbl_lu_r0",      5'd0, 5'd0, 1, 1, 0, 1, 5'd0, 0, NONE);
        tbl[3]  = mkv("tbl_lu_rt",      5'd1, 5'd7, 1, 1, 0, 1, 5'd7, 0, LU);
        tbl[4]  = mkv("tbl_lu_rs_unused", 5'd3, 5'd0, 0, 0, 0, 1, 5'd3, 0, NONE);
        tbl[5]  = mkv("tbl_no_load",    5'd3, 5'd3, 1, 1, 0, 0, 5'd3, 0, NONE);
        tbl[6]  = mkv("tbl_branch",     5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, BR);
        tbl[7]  = mkv("tbl_branch_jump", 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 1, BR);
        tbl[8]  = mkv("tbl_jump",       5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, JMP);
        tbl[9]  = mkv("tbl_lu_over_jump", 5'd9, 5'd0, 1, 0, 1, 1, 5'd9, 0, LU);
        tbl[10] = mkv("tbl_br_over_lu", 5'd4, 5'd0, 1, 0, 0, 1, 5'd4, 1, BR);
        tbl[11] = mkv("tbl_lu_mismatch", 5'd5, 5'd6, 1, 1, 0, 1, 5'd8, 0, NONE);

        // Reset with every hazard input active: all outputs must be 0.
        reset = 1'b1;
        cur = idle_v();
        cur.memacc = 1'b1; cur.muldiv = 1'b1; cur.br = 1'b1; cur.jump = 1'b1;
        drive(cur);
        @(negedge clk);
        check("reset_outs_a", outs_a, NONE);
        check("reset_outs_b", outs_b, NONE);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(idle_v());

        for (int i = 0; i < 12; i++) step(tbl[i]);

        // Load-use lasts one cycle once the load has moved on.
        cur = tbl[1];
        step(cur);
        cur.memread = 1'b0;
        sq("lu_released", NONE);

        // Memory access: request, 3 waits, Ack, no re-request.
        cur = idle_v();
        cur.memacc = 1'b1;
        sq("mem_req", MEMR);
        for (int i = 0; i < 3; i++) sq("mem_wait", MEMW);
        cur.ack = 1'b1;
        sq("mem_ack", MEMACK);
        cur.ack = 1'b0;
        sq("mem_no_rereq", NONE);
        cur.memacc = 1'b0;
        sq("mem_after", NONE);

        // Ack during the request cycle is ignored.
        cur.memacc = 1'b1; cur.ack = 1'b1;
        sq("mem_req_early_ack", MEMR);
        cur.ack = 1'b0;
        sq("mem_wait_after_early_ack", MEMW);
        cur.ack = 1'b1;
        sq("mem_ack2", MEMACK);
        cur.ack = 1'b0; cur.memacc = 1'b0;
        sq("mem2_after", NONE);

        // Mul/div with MULDIV_CYCLES=4.
        cur = idle_v();
        cur.muldiv = 1'b1;
        sq("md_start", MDS);
        for (int i = 0; i < 2; i++) sq("md_busy", MDB);
        sq("md_end", MDEND);
        cur.muldiv = 1'b0;
        sq("md_after", NONE);

        // Memory + mul/div + branch resolved in order.
        cur = idle_v();
        cur.memacc = 1'b1; cur.muldiv = 1'b1; cur.br = 1'b1;
        sq("sim_mem_req", MEMR);
        sq("sim_mem_wait", MEMW);
        sq("sim_mem_wait", MEMW);
        cur.ack = 1'b1;
        sq("sim_mem_ack", MEMACK);
        cur.ack = 1'b0;
        sq("sim_md_start", MDS);
        cur.memacc = 1'b0;
        sq("sim_md_busy", MDB);
        sq("sim_md_busy", MDB);
        sq("sim_md_end", MDEND);
        cur.muldiv = 1'b0;
        sq("sim_branch", BR);
        cur.br = 1'b0;
        sq("sim_after", NONE);

        // Reset mid-MEM_WAIT; a late Ack is ignored.
        cur = idle_v();
        cur.memacc = 1'b1;
        sq("rmem_req", MEMR);
        sq("rmem_wait", MEMW);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check("rmem_reset_outs", outs_a, NONE);
        @(posedge clk);
        #1 reset = 1'b0;
        cur.memacc = 1'b0; cur.ack = 1'b1;
        drive(cur);
        @(negedge clk);
        check("rmem_late_ack", outs_a, NONE);
        cur.ack = 1'b0;
        sq("rmem_after", NONE);

        // Reset mid-MD_BUSY at count 10 on the 32-cycle instance.
        pulse_reset();
        use_b = 1'b1;
        cur = idle_v();
        sq("b_idle", NONE);
        cur.muldiv = 1'b1;
        sq("b_md_start", MDS);
        cur.muldiv = 1'b0;
        for (int i = 0; i < 20; i++) sq("b_md_busy", MDB);
        @(posedge clk);
        #1;
        check("b_md_busy_cnt10", outs_b, MDB);
        #1 reset = 1'b1;
        #1 check("b_reset_outs", outs_b, NONE);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("b_after_reset", outs_b, NONE);

        // Full 32-cycle occupancy after the abort.
        cur.muldiv = 1'b1;
        sq("b_md_start2", MDS);
        cur.muldiv = 1'b0;
        for (int i = 0; i < 30; i++) sq("b_md_busy2", MDB);
        sq("b_md_end2", MDEND);
        sq("b_md_after2", NONE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
